// File: rtl/genesis_rom_loader.sv
// genesis_rom_loader: bridges the HPS ioctl download stream to the DDR3 ROM
// write port. Each 16-bit word becomes a toggle-handshake write, with a
// one-entry skid buffer and ioctl_wait throttling. The block also tracks the
// image size, derives a power-of-two mask, and scans the header region field.
module genesis_rom_loader #(
   parameter int AW = 25
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic          ioctl_wr,
   input  logic [AW-1:0] ioctl_addr,
   input  logic [15:0]   ioctl_data,
   output logic          ioctl_wait,
   output logic [AW-1:0] wraddr,
   output logic [15:0]   din,
   output logic          we_req,
   input  logic          we_ack,
   input  logic          auto_region,
   output logic [AW-1:0] rom_size,
   output logic [AW-1:0] rom_mask,
   output logic [1:0]    region_req,
   output logic          region_valid,
   output logic          region_set,
   output logic          load_done,
   output logic          overflow
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

   localparam logic [7:0] CH_U = 8'h55;
   localparam logic [7:0] CH_J = 8'h4A;
   localparam logic [7:0] CH_E = 8'h45;

   state_t        r_state;
   logic          r_dl_q;
   logic          r_rise_pend;
   logic          r_wait;
   logic [AW-1:0] r_wraddr;
   logic [15:0]   r_din;
   logic          r_we_req;
   logic          r_skid_full;
   logic [AW-1:0] r_skid_addr;
   logic [15:0]   r_skid_data;
   logic [AW-1:0] r_rom_size;
   logic [AW-1:0] r_rom_mask;
   logic          r_has_u, r_has_j, r_has_e;
   logic [1:0]    r_region_req;
   logic          r_region_valid;
   logic          r_region_set;
   logic          r_load_done;
   logic          r_overflow;

   logic          w_rise;
   logic          w_idle;
   logic          w_wr;
   logic          w_take;
   logic          w_direct;
   logic          w_skid_st;
   logic          w_release;
   logic          w_drop;
   logic          w_drained;
   logic [AW-1:0] w_addr_p2;
   logic          w_hdr0, w_hdr2;
   logic [7:0]    w_lo, w_hi;
   logic          w_u_nx, w_j_nx, w_e_nx;
   logic [1:0]    w_req_nx;
   logic [AW-1:0] w_m1;
   logic [AW-1:0] w_mask;

   assign w_rise    = ioctl_download & ~r_dl_q;
   assign w_idle    = (r_we_req == we_ack);
   assign w_wr      = ioctl_wr & (r_state == S_LOAD);
   // a word is accepted (issued or skidded) only when the skid has room
   assign w_take    = w_wr & ~r_skid_full;
   assign w_direct  = w_take & w_idle;
   assign w_skid_st = w_take & ~w_idle;
   assign w_release = r_skid_full & w_idle;
   assign w_drop    = w_wr & r_skid_full;
   assign w_drained = w_idle & ~r_skid_full;
   assign w_addr_p2 = ioctl_addr + AW'(2);

   assign w_lo   = ioctl_data[7:0];
   assign w_hi   = ioctl_data[15:8];
   assign w_hdr0 = w_take && (ioctl_addr == AW'(12'h1F0));
   assign w_hdr2 = w_take && (ioctl_addr == AW'(12'h1F2));

   // sticky per-character flags so priority holds regardless of arrival order
   assign w_u_nx = r_has_u | (w_hdr0 & ((w_lo == CH_U) | (w_hi == CH_U))) | (w_hdr2 & (w_lo == CH_U));
   assign w_j_nx = r_has_j | (w_hdr0 & ((w_lo == CH_J) | (w_hi == CH_J))) | (w_hdr2 & (w_lo == CH_J));
   assign w_e_nx = r_has_e | (w_hdr0 & ((w_lo == CH_E) | (w_hi == CH_E))) | (w_hdr2 & (w_lo == CH_E));
   assign w_req_nx = w_u_nx ? 2'd1 : w_j_nx ? 2'd0 : w_e_nx ? 2'd2 : 2'd0;

   // smear (size-1) downward to get the smallest 2^n-1 covering the image
   assign w_m1 = r_rom_size - AW'(1);
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < AW; i++) w_mask[i] = |(w_m1 >> i);
   end

   // load FSM, write handshake, skid buffer, size and header tracking
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_dl_q         <= 1'b0;
         r_rise_pend    <= 1'b0;
         r_wait         <= 1'b0;
         r_wraddr       <= '0;
         r_din          <= '0;
         r_we_req       <= 1'b0;
         r_skid_full    <= 1'b0;
         r_skid_addr    <= '0;
         r_skid_data    <= '0;
         r_rom_size     <= '0;
         r_rom_mask     <= '0;
         r_has_u        <= 1'b0;
         r_has_j        <= 1'b0;
         r_has_e        <= 1'b0;
         r_region_req   <= 2'd0;
         r_region_valid <= 1'b0;
         r_region_set   <= 1'b0;
         r_load_done    <= 1'b0;
         r_overflow     <= 1'b0;
      end else begin
         r_dl_q       <= ioctl_download;
         r_load_done  <= 1'b0;
         r_region_set <= 1'b0;

         // a new download seen before we are back in IDLE is deferred
         if (w_rise && r_state != S_IDLE) r_rise_pend <= 1'b1;

         if (w_direct) begin
            r_wraddr <= ioctl_addr;
            r_din    <= {ioctl_data[7:0], ioctl_data[15:8]};
            r_we_req <= ~r_we_req;
         end else if (w_release) begin
            r_wraddr    <= r_skid_addr;
            r_din       <= {r_skid_data[7:0], r_skid_data[15:8]};
            r_we_req    <= ~r_we_req;
            r_skid_full <= 1'b0;
         end
         if (w_skid_st) begin
            r_skid_full <= 1'b1;
            r_skid_addr <= ioctl_addr;
            r_skid_data <= ioctl_data;
         end
         if (w_drop) r_overflow <= 1'b1;

         if (w_wr)           r_wait <= 1'b1;
         else if (w_drained) r_wait <= 1'b0;

         if (w_take) begin
            if (w_addr_p2 > r_rom_size) r_rom_size <= w_addr_p2;
            r_has_u        <= w_u_nx;
            r_has_j        <= w_j_nx;
            r_has_e        <= w_e_nx;
            r_region_req   <= w_req_nx;
            r_region_valid <= w_u_nx | w_j_nx | w_e_nx;
         end

         case (r_state)
            S_IDLE: begin
               if (w_rise || r_rise_pend) begin
                  r_state        <= S_LOAD;
                  r_rise_pend    <= 1'b0;
                  r_rom_size     <= '0;
                  r_rom_mask     <= '0;
                  r_has_u        <= 1'b0;
                  r_has_j        <= 1'b0;
                  r_has_e        <= 1'b0;
                  r_region_req   <= 2'd0;
                  r_region_valid <= 1'b0;
                  r_overflow     <= 1'b0;
               end
            end
            S_LOAD: begin
               // level test: a download that already fell still ends the load
               if (!ioctl_download) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (w_drained) begin
                  r_state      <= S_IDLE;
                  r_rom_mask   <= (r_rom_size == '0) ? '0 : w_mask;
                  r_load_done  <= 1'b1;
                  r_region_set <= auto_region & r_region_valid;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ioctl_wait   = r_wait;
   assign wraddr       = r_wraddr;
   assign din          = r_din;
   assign we_req       = r_we_req;
   assign rom_size     = r_rom_size;
   assign rom_mask     = r_rom_mask;
   assign region_req   = r_region_req;
   assign region_valid = r_region_valid;
   assign region_set   = r_region_set;
   assign load_done    = r_load_done;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_genesis_rom_loader.sv
// Directed bench for genesis_rom_loader: handshake, skid, size/mask,
// header region scan, drain/restart and asynchronous reset.
module tb_genesis_rom_loader;
   localparam int AW = 25;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          ioctl_download = 1'b0;
   logic          ioctl_wr = 1'b0;
   logic [AW-1:0] ioctl_addr = '0;
   logic [15:0]   ioctl_data = '0;
   logic          ioctl_wait;
   logic [AW-1:0] wraddr;
   logic [15:0]   din;
   logic          we_req;
   logic          we_ack = 1'b0;
   logic          auto_region = 1'b0;
   logic [AW-1:0] rom_size;
   logic [AW-1:0] rom_mask;
   logic [1:0]    region_req;
   logic          region_valid;
   logic          region_set;
   logic          load_done;
   logic          overflow;

   int   n_chk = 0;
   int   n_pass = 0;
   logic exp_req = 1'b0;

   genesis_rom_loader #(.AW(AW)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
      .ioctl_wait(ioctl_wait), .wraddr(wraddr), .din(din), .we_req(we_req),
      .we_ack(we_ack), .auto_region(auto_region), .rom_size(rom_size),
      .rom_mask(rom_mask), .region_req(region_req), .region_valid(region_valid),
      .region_set(region_set), .load_done(load_done), .overflow(overflow)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic start_dl();
      ioctl_download = 1'b1;
      tick();
   endtask

   // falling download: one edge into DRAIN, one edge to finish (if idle)
   task automatic end_dl();
      ioctl_download = 1'b0;
      tick();
      tick();
   endtask

   task automatic strobe(input logic [AW-1:0] a, input logic [15:0] d);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic ack();
      we_ack = ~we_ack;
      tick();
   endtask

   task automatic wr_word(input logic [AW-1:0] a, input logic [15:0] d);
      strobe(a, d);
      exp_req = ~exp_req;
      chk("ww_req", 32'(we_req), 32'(exp_req));
      chk("ww_addr", 32'(wraddr), 32'(a));
      chk("ww_din", 32'(din), 32'({d[7:0], d[15:8]}));
      chk("ww_wait_hi", 32'(ioctl_wait), 32'd1);
      ack();
      chk("ww_wait_lo", 32'(ioctl_wait), 32'd0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_req", 32'(we_req), 32'd0);
      chk("rst_wait", 32'(ioctl_wait), 32'd0);
      chk("rst_size", 32'(rom_size), 32'd0);
      chk("rst_mask", 32'(rom_mask), 32'd0);
      chk("rst_done", 32'(load_done), 32'd0);
      reset = 1'b0;
      tick();

      // single word, ack after 3 cycles
      start_dl();
      strobe(25'h10, 16'h3412);
      exp_req = 1'b1;
      chk("s1_req", 32'(we_req), 32'd1);
      chk("s1_din", 32'(din), 32'h1234);
      chk("s1_addr", 32'(wraddr), 32'h10);
      chk("s1_wait0", 32'(ioctl_wait), 32'd1);
      tick();
      chk("s1_wait1", 32'(ioctl_wait), 32'd1);
      tick();
      chk("s1_wait2", 32'(ioctl_wait), 32'd1);
      ack();
      chk("s1_wait_drop", 32'(ioctl_wait), 32'd0);
      chk("s1_size", 32'(rom_size), 32'h12);
      end_dl();
      chk("s1_done", 32'(load_done), 32'd1);
      chk("s1_mask", 32'(rom_mask), 32'h1F);
      chk("s1_rset", 32'(region_set), 32'd0);
      tick();
      chk("s1_done_pulse", 32'(load_done), 32'd0);

      // skid and overflow
      start_dl();
      strobe(25'h0, 16'hAAAA);
      exp_req = ~exp_req;
      chk("sk_req0", 32'(we_req), 32'(exp_req));
      tick();
      strobe(25'h2, 16'h5555);
      chk("sk_req_hold", 32'(we_req), 32'(exp_req));
      chk("sk_addr_hold", 32'(wraddr), 32'h0);
      chk("sk_ovf0", 32'(overflow), 32'd0);
      tick();
      strobe(25'h4, 16'h1111);
      chk("sk_ovf1", 32'(overflow), 32'd1);
      ack();
      exp_req = ~exp_req;
      chk("sk_rel_req", 32'(we_req), 32'(exp_req));
      chk("sk_rel_addr", 32'(wraddr), 32'h2);
      chk("sk_rel_din", 32'(din), 32'h5555);
      chk("sk_rel_wait", 32'(ioctl_wait), 32'd1);
      ack();
      chk("sk_wait_lo", 32'(ioctl_wait), 32'd0);
      chk("sk_size", 32'(rom_size), 32'h4);
      end_dl();
      chk("sk_done", 32'(load_done), 32'd1);
      chk("sk_mask", 32'(rom_mask), 32'h3);
      chk("sk_ovf_sticky", 32'(overflow), 32'd1);

      // size/mask
      start_dl();
      chk("sz_ovf_clr", 32'(overflow), 32'd0);
      chk("sz_size_clr", 32'(rom_size), 32'd0);
      wr_word(25'h17FFFE, 16'h0102);
      wr_word(25'h100, 16'h0304);
      chk("sz_size", 32'(rom_size), 32'h180000);
      end_dl();
      chk("sz_done", 32'(load_done), 32'd1);
      chk("sz_mask", 32'(rom_mask), 32'h1FFFFF);
      start_dl();
      end_dl();
      chk("em_done", 32'(load_done), 32'd1);
      chk("em_size", 32'(rom_size), 32'd0);
      chk("em_mask", 32'(rom_mask), 32'd0);

      // region "JUE"
      auto_region = 1'b1;
      start_dl();
      wr_word(25'h1F0, 16'h554A);
      wr_word(25'h1F2, 16'h2045);
      chk("rg1_req", 32'(region_req), 32'd1);
      chk("rg1_valid", 32'(region_valid), 32'd1);
      end_dl();
      chk("rg1_done", 32'(load_done), 32'd1);
      chk("rg1_set", 32'(region_set), 32'd1);
      tick();
      chk("rg1_set_pulse", 32'(region_set), 32'd0);

      // region "E  " with auto_region off
      auto_region = 1'b0;
      start_dl();
      chk("rg2_valid_clr", 32'(region_valid), 32'd0);
      wr_word(25'h1F0, 16'h2045);
      wr_word(25'h1F2, 16'h2020);
      end_dl();
      chk("rg2_req", 32'(region_req), 32'd2);
      chk("rg2_valid", 32'(region_valid), 32'd1);
      chk("rg2_set", 32'(region_set), 32'd0);

      // region priority with reversed arrival: J at 0x1F2 first, then E,U
      auto_region = 1'b1;
      start_dl();
      wr_word(25'h1F2, 16'h204A);
      chk("rg3_req_j", 32'(region_req), 32'd0);
      wr_word(25'h1F0, 16'h5545);
      end_dl();
      chk("rg3_req", 32'(region_req), 32'd1);
      chk("rg3_set", 32'(region_set), 32'd1);

      // spaces only
      start_dl();
      wr_word(25'h1F0, 16'h2020);
      wr_word(25'h1F2, 16'h2020);
      end_dl();
      chk("rg4_valid", 32'(region_valid), 32'd0);
      chk("rg4_set", 32'(region_set), 32'd0);
      chk("rg4_done", 32'(load_done), 32'd1);

      // drain with outstanding write, restart during drain
      start_dl();
      strobe(25'h0, 16'h0A0B);
      exp_req = ~exp_req;
      tick();
      strobe(25'h2, 16'h0C0D);
      tick();
      strobe(25'h4, 16'h0E0F);
      chk("dr_ovf", 32'(overflow), 32'd1);
      ioctl_download = 1'b0;
      tick();
      tick();
      tick();
      chk("dr_wait_done0", 32'(load_done), 32'd0);
      ioctl_download = 1'b1;
      tick();
      tick();
      chk("dr_wait_done1", 32'(load_done), 32'd0);
      ack();
      exp_req = ~exp_req;
      chk("dr_rel_req", 32'(we_req), 32'(exp_req));
      chk("dr_rel_addr", 32'(wraddr), 32'h2);
      chk("dr_wait_done2", 32'(load_done), 32'd0);
      ack();
      chk("dr_done", 32'(load_done), 32'd1);
      tick();
      chk("dr_restart_ovf", 32'(overflow), 32'd0);
      chk("dr_restart_size", 32'(rom_size), 32'd0);
      chk("dr_done_pulse", 32'(load_done), 32'd0);
      wr_word(25'h20, 16'hBEEF);
      end_dl();
      chk("dr2_done", 32'(load_done), 32'd1);
      chk("dr2_size", 32'(rom_size), 32'h22);

      // asynchronous reset with skid full
      start_dl();
      strobe(25'h40, 16'h1122);
      exp_req = ~exp_req;
      tick();
      strobe(25'h42, 16'h3344);
      reset = 1'b1;
      #1;
      chk("ar_req", 32'(we_req), 32'd0);
      chk("ar_wait", 32'(ioctl_wait), 32'd0);
      chk("ar_addr", 32'(wraddr), 32'd0);
      chk("ar_din", 32'(din), 32'd0);
      chk("ar_size", 32'(rom_size), 32'd0);
      we_ack = 1'b0;
      exp_req = 1'b0;
      ioctl_download = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      start_dl();
      wr_word(25'h10, 16'h3412);
      chk("ar_din_after", 32'(din), 32'h1234);
      end_dl();
      chk("ar_done", 32'(load_done), 32'd1);
      chk("ar_size_after", 32'(rom_size), 32'h12);
      chk("ar_mask_after", 32'(rom_mask), 32'h1F);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
